// File: rtl/uart_value_reporter_pkg.sv
// Shared constants, FSM encoding and byte-selection helper for the UART value reporter.
package uart_value_reporter_pkg;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam int         FRAME_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Byte idx of the frame for value val: tens digit, ones digit, CR, LF.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [3:0] val);
    logic       tens;
    logic [3:0] ones;
    tens = (val >= 4'd10);
    ones = tens ? (val - 4'd10) : val;
    case (idx)
      2'd0:    frame_byte = ASCII_0 + {7'd0, tens};
      2'd1:    frame_byte = ASCII_0 + {4'd0, ones};
      2'd2:    frame_byte = ASCII_CR;
      default: frame_byte = ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/uart_value_reporter_tx.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit; idle high.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       FPGA_CLK,
  input  logic       RESET_BUT,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_active,
  output logic       tx_done,
  output logic       txd
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       STOP_IDX  = 4'd9;

  logic             active_q;
  logic [CNT_W-1:0] baud_q;
  logic [3:0]       bit_q;
  logic [8:0]       shift_q;   // remaining bits to send: d0..d7 then stop
  logic             txd_q;
  logic             bit_end;

  assign bit_end   = active_q && (baud_q == BAUD_LAST);
  // Asserted in the last cycle of the stop bit so the next byte can follow with minimal gap.
  assign tx_done   = bit_end && (bit_q == STOP_IDX);
  assign tx_active = active_q;
  assign txd       = txd_q;

  // Bit timing and shifting; the line is driven straight from txd_q so it cannot glitch.
  always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
    if (RESET_BUT) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      txd_q    <= 1'b1;
    end else if (!active_q) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (tx_start) begin
        active_q <= 1'b1;
        baud_q   <= '0;
        bit_q    <= '0;
        shift_q  <= {1'b1, tx_byte};
        txd_q    <= 1'b0;
      end
    end else if (bit_end) begin
      baud_q <= '0;
      if (bit_q == STOP_IDX) begin
        active_q <= 1'b0;
        bit_q    <= '0;
        txd_q    <= 1'b1;
      end else begin
        bit_q   <= bit_q + 4'd1;
        txd_q   <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
      end
    end else begin
      baud_q <= baud_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_value_reporter.sv
// Reports the 4-bit counter value as "<tens><ones>\r\n" over UART on change or request.
module uart_value_reporter
  import uart_value_reporter_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int CHANGE_TRIG = 1
) (
  input  logic       FPGA_CLK,
  input  logic       RESET_BUT,
  input  logic [3:0] data,
  input  logic       send_req,
  output logic       UART_TXD,
  output logic       busy,
  output logic       frame_done
);

  localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic       CHANGE_EN    = (CHANGE_TRIG != 0);
  localparam logic [1:0] LAST_IDX     = 2'(FRAME_LEN - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] val_q, val_d;
  logic [3:0] last_q, last_d;
  logic       pending_q, pending_d;
  logic       trig;
  logic       tx_start;
  logic       tx_active;
  logic       tx_done;
  logic [7:0] tx_byte;

  assign trig    = send_req | (CHANGE_EN & (data != last_q));
  assign tx_byte = frame_byte(idx_q, val_q);
  assign busy    = (state_q != ST_IDLE);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .FPGA_CLK (FPGA_CLK),
    .RESET_BUT(RESET_BUT),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_active(tx_active),
    .tx_done  (tx_done),
    .txd      (UART_TXD)
  );

  // Frame FSM and value registers.
  always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
    if (RESET_BUT) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      val_q     <= '0;
      last_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic: sequences four bytes, collapses triggers arriving mid-frame into one pending send.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    val_d      = val_q;
    last_d     = last_q;
    pending_d  = pending_q;
    tx_start   = 1'b0;
    frame_done = 1'b0;

    if (state_q != ST_IDLE && trig) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          val_d   = data;
          last_d  = data;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_start = !tx_active;
        state_d  = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        if (pending_q || trig) begin
          pending_d = 1'b0;
          val_d     = data;
          last_d    = data;
          idx_d     = '0;
          state_d   = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_value_reporter.sv
// Self-checking bench: UART line receiver plus ASCII frame model compared against decoded bytes.
module tb_uart_value_reporter;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 125_000;
  localparam int CPB    = CLK_HZ / BAUD;   // 8 clocks per bit keeps the run short

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data = 4'd0;
  logic       send_req = 1'b0;
  logic [3:0] data_nc = 4'd0;
  logic       send_req_nc = 1'b0;
  logic       txd, busy, frame_done;
  logic       txd_nc, busy_nc, frame_done_nc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_value_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANGE_TRIG(1)) dut (
    .FPGA_CLK  (clk),
    .RESET_BUT (rst),
    .data      (data),
    .send_req  (send_req),
    .UART_TXD  (txd),
    .busy      (busy),
    .frame_done(frame_done)
  );

  uart_value_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANGE_TRIG(0)) dut_nc (
    .FPGA_CLK  (clk),
    .RESET_BUT (rst),
    .data      (data_nc),
    .send_req  (send_req_nc),
    .UART_TXD  (txd_nc),
    .busy      (busy_nc),
    .frame_done(frame_done_nc)
  );

  // ---------------- line receiver (independent 8N1 decoder) ----------------
  logic [7:0] rx_q[$];
  int         rx_frame_err = 0;
  int         rst_epoch = 0;
  int         fd_cnt = 0;
  int         busy_cycles = 0;

  always @(posedge rst) rst_epoch++;
  always @(negedge clk) if (rst === 1'b0 && frame_done === 1'b1) fd_cnt++;
  always @(negedge clk) if (busy === 1'b1) busy_cycles++;

  always begin : rx_mon
    int         ep;
    logic [7:0] b;
    logic       start_mid, stop_bit;
    @(negedge clk iff (rst === 1'b0 && txd === 1'b0));
    ep = rst_epoch;
    repeat (CPB / 2) @(negedge clk);
    start_mid = txd;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = txd;
    end
    repeat (CPB) @(negedge clk);
    stop_bit = txd;
    if (ep == rst_epoch && rst === 1'b0) begin
      rx_q.push_back(b);
      if (start_mid !== 1'b0 || stop_bit !== 1'b1) rx_frame_err++;
    end
  end

  // ---------------- reference model and helpers ----------------
  logic [7:0] exp_q[$];
  int         rx_rd = 0;
  int         exp_fd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input int v);
    exp_q.push_back(8'(48 + v / 10));
    exp_q.push_back(8'(48 + v % 10));
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd10);
    exp_fd++;
  endtask

  task automatic compare_frames(input string tag);
    int got;
    got = rx_q.size() - rx_rd;
    check({tag, "_nbytes"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got; i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[rx_rd + i], exp_q[i]);
    check({tag, "_frame_done_cnt"}, fd_cnt, exp_fd);
    rx_rd = rx_q.size();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 150 * CPB) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, busy, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_value(input logic [3:0] v);
    data = v;
    @(negedge clk);
    wait_idle("send");
    expect_frame(v);
  endtask

  // Trigger a, then change to b and c while busy: exactly one follow-up frame carrying c.
  task automatic pend_case(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input string tag);
    data = a;
    repeat (3 * CPB) @(negedge clk);
    data = b;
    repeat (15 * CPB) @(negedge clk);
    data = c;
    wait_idle(tag);
    expect_frame(a);
    expect_frame(c);
    compare_frames(tag);
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    logic [3:0] v, a, b, c, x;
    int         n, bc0;
    logic       any_low;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_nc_txd", txd_nc, 1'b1);
    check("rst_nc_busy", busy_nc, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_no_trig_busy", busy, 1'b0);
    check("idle_no_trig_txd", txd, 1'b1);

    // 1: value 7, latency and bit timing
    bc0 = busy_cycles;
    data = 4'd7;
    @(negedge clk);
    check("t1_busy_n1", busy, 1'b1);
    check("t1_txd_n1", txd, 1'b1);
    @(negedge clk);
    check("t1_start_n2", txd, 1'b0);
    n = 1;
    while (txd === 1'b0 && n < 100 * CPB) begin
      @(negedge clk);
      if (txd === 1'b0) n++;
    end
    check("t1_low_run_len", n, 5 * CPB);   // start + four zero LSBs of 0x30
    wait_idle("t1");
    n = busy_cycles - bc0;
    check("t1_busy_len_in_range", (n >= 40 * CPB && n <= 40 * CPB + 12), 1'b1);
    expect_frame(7);
    compare_frames("t1");

    // 2: two-digit values
    send_value(4'd12);
    send_value(4'd15);
    compare_frames("t2");

    // random value changes
    for (int k = 0; k < 4; k++) begin
      v = 4'($urandom_range(15));
      if (v == data) v = v + 4'd1;
      send_value(v);
    end
    compare_frames("rand");

    // 3: changes while busy collapse to one frame with the latest value
    pend_case(4'd3, 4'd4, 4'd5, "t3");
    a = 4'($urandom_range(15));
    if (a == data) a = a + 4'd1;
    b = 4'(a + 4'd1 + 4'($urandom_range(14)));
    c = 4'($urandom_range(15));
    pend_case(a, b, c, "t3_rand");

    // 4: send_req with stable data
    send_value(4'd9);
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    wait_idle("t4");
    expect_frame(9);
    compare_frames("t4");

    // 4b: change-trigger disabled instance
    data_nc = 4'($urandom_range(1, 15));
    any_low = 1'b0;
    repeat (20 * CPB) begin
      @(negedge clk);
      if (txd_nc !== 1'b1) any_low = 1'b1;
    end
    check("t4_nc_no_tx_on_change", any_low, 1'b0);
    check("t4_nc_not_busy", busy_nc, 1'b0);
    send_req_nc = 1'b1;
    @(negedge clk);
    send_req_nc = 1'b0;
    check("t4_nc_req_busy", busy_nc, 1'b1);
    @(negedge clk);
    check("t4_nc_req_start", txd_nc, 1'b0);
    n = 0;
    while (busy_nc === 1'b1 && n < 150 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("t4_nc_idle_timeout", busy_nc, 1'b0);

    // 5: reset in the middle of byte1, then a fresh frame for 6
    x = (data == 4'd2) ? 4'd4 : 4'd2;
    data = x;
    @(negedge clk);
    repeat (13 * CPB) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_txd", txd, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_frame_done", frame_done, 1'b0);
    data = 4'd6;
    repeat (12 * CPB) @(negedge clk);
    rx_rd = rx_q.size();
    rst = 1'b0;
    @(negedge clk);
    check("t5_release_busy", busy, 1'b1);
    wait_idle("t5");
    expect_frame(6);
    compare_frames("t5");

    // 6: send_req in the DONE cycle yields a second frame
    v = 4'($urandom_range(15));
    if (v == data) v = v + 4'd1;
    data = v;
    n = 0;
    while (frame_done !== 1'b1 && n < 60 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("t6_saw_frame_done", frame_done, 1'b1);
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    check("t6_still_busy", busy, 1'b1);
    wait_idle("t6");
    expect_frame(v);
    expect_frame(v);
    compare_frames("t6");

    check("rx_framing_errors", rx_frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
